// File: rtl/atm_pkg.sv
// Shared types and constants for the dual-ATM account-store controller.
package atm_pkg;

  localparam logic [1:0] OP_BAL = 2'b00;
  localparam logic [1:0] OP_DEP = 2'b01;
  localparam logic [1:0] OP_WDR = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin pick; the requester that did not win last time wins a tie.
module rr_arbiter_2
  import atm_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);

  always_comb begin
    grant_valid = req_a | req_b;
    grant_id    = REQ_A;
    if (req_a && req_b) begin
      grant_id = (last_grant == REQ_A) ? REQ_B : REQ_A;
    end else if (req_b) begin
      grant_id = REQ_B;
    end
  end

endmodule

// File: rtl/atm_account_arbiter.sv
// Account-store controller shared by two ATM front-ends: arbitrates, executes
// balance/deposit/withdraw against one balance bank, returns per-side results.
module atm_account_arbiter
  import atm_pkg::*;
#(
  parameter int                 NUM_ACCOUNTS = 4,
  parameter int                 ACCT_W       = 2,
  parameter int                 BAL_W        = 32,
  parameter int                 AMT_W        = 7,
  parameter int unsigned        INIT_BALANCE = 500,
  parameter logic [BAL_W-1:0]   MAX_BALANCE  = {BAL_W{1'b1}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_a,
  input  logic [1:0]        op_a,
  input  logic [ACCT_W-1:0] acct_a,
  input  logic [AMT_W-1:0]  amt_a,
  input  logic              req_b,
  input  logic [1:0]        op_b,
  input  logic [ACCT_W-1:0] acct_b,
  input  logic [AMT_W-1:0]  amt_b,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              done_a,
  output logic              done_b,
  output logic              ok_a,
  output logic              ok_b,
  output logic [BAL_W-1:0]  bal_a,
  output logic [BAL_W-1:0]  bal_b,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  // Handshake: a requester raises req_x with op/acct/amt stable and holds it
  // until it sees done_x; it drops req_x on the following edge. gnt_x marks the
  // transaction in flight, done_x pulses once, ok_x/bal_x hold until the next done_x.

  localparam logic [ACCT_W:0] NUM_ACCT_L = (ACCT_W+1)'(NUM_ACCOUNTS);

  state_t              state_q, state_d;
  logic                last_grant;
  logic                cur_id;
  logic [1:0]          op_q;
  logic [ACCT_W-1:0]   acct_q;
  logic [AMT_W-1:0]    amt_q;
  logic [BAL_W-1:0]    bal_mem [NUM_ACCOUNTS];

  logic                grant_valid;
  logic                grant_id;

  logic                acct_ok;
  logic [BAL_W-1:0]    cur_bal;
  logic [BAL_W:0]      sum;
  logic [BAL_W-1:0]    amt_ext;
  logic                res_ok;
  logic [BAL_W-1:0]    res_bal;
  logic                wr_en;

  rr_arbiter_2 u_arb (
    .req_a       (req_a),
    .req_b       (req_b),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_valid) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

  // Deposit overflow is judged on a BAL_W+1 bit sum so the carry is never lost.
  always_comb begin
    acct_ok = ({1'b0, acct_q} < NUM_ACCT_L);
    cur_bal = acct_ok ? bal_mem[acct_q] : '0;
    sum     = {1'b0, cur_bal} + {{(BAL_W+1-AMT_W){1'b0}}, amt_q};
    amt_ext = {{(BAL_W-AMT_W){1'b0}}, amt_q};
    res_ok  = 1'b0;
    res_bal = cur_bal;
    wr_en   = 1'b0;
    if (acct_ok) begin
      case (op_q)
        OP_BAL: res_ok = 1'b1;
        OP_DEP: begin
          if (sum <= {1'b0, MAX_BALANCE}) begin
            res_ok  = 1'b1;
            res_bal = sum[BAL_W-1:0];
            wr_en   = 1'b1;
          end
        end
        OP_WDR: begin
          if (amt_ext <= cur_bal) begin
            res_ok  = 1'b1;
            res_bal = cur_bal - amt_ext;
            wr_en   = 1'b1;
          end
        end
        default: res_ok = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= REQ_B;
      cur_id     <= REQ_A;
      op_q       <= OP_BAL;
      acct_q     <= '0;
      amt_q      <= '0;
      gnt_a      <= 1'b0;
      gnt_b      <= 1'b0;
      done_a     <= 1'b0;
      done_b     <= 1'b0;
      ok_a       <= 1'b0;
      ok_b       <= 1'b0;
      bal_a      <= '0;
      bal_b      <= '0;
      for (int i = 0; i < NUM_ACCOUNTS; i++) begin
        bal_mem[i] <= BAL_W'(INIT_BALANCE);
      end
    end else begin
      done_a <= 1'b0;
      done_b <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_valid) begin
            cur_id     <= grant_id;
            last_grant <= grant_id;
            gnt_a      <= (grant_id == REQ_A);
            gnt_b      <= (grant_id == REQ_B);
            if (grant_id == REQ_A) begin
              op_q   <= op_a;
              acct_q <= acct_a;
              amt_q  <= amt_a;
            end else begin
              op_q   <= op_b;
              acct_q <= acct_b;
              amt_q  <= amt_b;
            end
          end
        end
        EXEC: begin
          if (wr_en) bal_mem[acct_q] <= res_bal;
          if (cur_id == REQ_A) begin
            done_a <= 1'b1;
            ok_a   <= res_ok;
            bal_a  <= res_bal;
          end else begin
            done_b <= 1'b1;
            ok_b   <= res_ok;
            bal_b  <= res_bal;
          end
        end
        RESP: begin
          gnt_a <= 1'b0;
          gnt_b <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_atm_account_arbiter.sv
// Directed bench for atm_account_arbiter with a scoreboard of expected completions.
module tb_atm_account_arbiter;
  import atm_pkg::*;

  localparam int     BW   = 10;
  localparam longint MAXB = (64'd1 << BW) - 1;

  logic          Clock_tb = 1'b0;
  logic          reset;
  logic          req_a, req_b;
  logic [1:0]    op_a, op_b;
  logic [1:0]    acct_a, acct_b;
  logic [6:0]    amt_a, amt_b;
  logic          gnt_a, gnt_b, done_a, done_b, ok_a, ok_b, busy;
  logic [BW-1:0] bal_a, bal_b;
  logic [1:0]    dbg_state;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [BW+1:0] exp_q[$];
  logic          gnt_log[$];
  longint        model_bal[4];
  logic          gnt_a_prev = 1'b0;
  logic          gnt_b_prev = 1'b0;

  atm_account_arbiter #(.BAL_W(BW)) dut (
    .clk(Clock_tb), .reset(reset),
    .req_a(req_a), .op_a(op_a), .acct_a(acct_a), .amt_a(amt_a),
    .req_b(req_b), .op_b(op_b), .acct_b(acct_b), .amt_b(amt_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .done_a(done_a), .done_b(done_b),
    .ok_a(ok_a), .ok_b(ok_b), .bal_a(bal_a), .bal_b(bal_b),
    .busy(busy), .dbg_state(dbg_state)
  );

  // clock
  always #5 Clock_tb = ~Clock_tb;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_txn(input logic id, input logic [1:0] op,
                                    input logic [1:0] acct, input logic [6:0] amt);
    longint        cur, nb, a;
    logic          ok;
    logic [BW-1:0] b;
    cur = model_bal[acct];
    a   = longint'(amt);
    nb  = cur;
    ok  = 1'b0;
    case (op)
      2'b00: ok = 1'b1;
      2'b01: if (cur + a <= MAXB) begin ok = 1'b1; nb = cur + a; end
      2'b10: if (a <= cur) begin ok = 1'b1; nb = cur - a; end
      default: ok = 1'b0;
    endcase
    model_bal[acct] = nb;
    b = nb[BW-1:0];
    exp_q.push_back({id, ok, b});
  endfunction

  // scoreboard monitor
  always @(negedge Clock_tb) begin
    logic [BW+1:0] e;
    chk("gnt_excl", {31'b0, gnt_a & gnt_b}, 32'd0);
    if (gnt_a && !gnt_a_prev) gnt_log.push_back(REQ_A);
    if (gnt_b && !gnt_b_prev) gnt_log.push_back(REQ_B);
    gnt_a_prev = gnt_a;
    gnt_b_prev = gnt_b;
    if (done_a || done_b) begin
      chk("done_excl", {31'b0, done_a & done_b}, 32'd0);
      chk("sb_pending", {31'b0, exp_q.size() > 0}, 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_id",  {31'b0, done_b}, {31'b0, e[BW+1]});
        chk("sb_ok",  {31'b0, done_b ? ok_b : ok_a}, {31'b0, e[BW]});
        chk("sb_bal", 32'(done_b ? bal_b : bal_a), 32'(e[BW-1:0]));
      end
    end
  end

  // driver
  task automatic txn(input logic id, input logic [1:0] op, input logic [1:0] acct,
                     input logic [6:0] amt);
    int   n;
    logic seen;
    model_txn(id, op, acct, amt);
    @(negedge Clock_tb);
    if (id == REQ_A) begin op_a = op; acct_a = acct; amt_a = amt; req_a = 1'b1; end
    else             begin op_b = op; acct_b = acct; amt_b = amt; req_b = 1'b1; end
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge Clock_tb);
      n++;
      seen = (id == REQ_A) ? done_a : done_b;
    end
    chk("latency", n, 32'd2);
    chk("gnt_hold", {31'b0, (id == REQ_A) ? gnt_a : gnt_b}, 32'd1);
    req_a = 1'b0;
    req_b = 1'b0;
  endtask

  initial begin
    int na, nb;
    req_a = 0; op_a = 0; acct_a = 0; amt_a = 0;
    req_b = 0; op_b = 0; acct_b = 0; amt_b = 0;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) model_bal[i] = 500;
    repeat (2) @(negedge Clock_tb);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_state", {30'b0, dbg_state}, 32'd0);
    chk("rst_gnt", {30'b0, gnt_a, gnt_b}, 32'd0);
    chk("rst_done", {30'b0, done_a, done_b}, 32'd0);
    chk("rst_ok", {30'b0, ok_a, ok_b}, 32'd0);
    chk("rst_bal_a", 32'(bal_a), 32'd0);
    chk("rst_bal_b", 32'(bal_b), 32'd0);
    reset = 1'b1;

    // basic query, then B side untouched
    txn(REQ_A, OP_BAL, 2'd0, 7'd0);
    chk("b_idle_ok", {31'b0, ok_b}, 32'd0);
    chk("b_idle_bal", 32'(bal_b), 32'd0);

    // shared account: B sees A's write-back
    txn(REQ_A, OP_DEP, 2'd1, 7'd100);
    txn(REQ_B, OP_WDR, 2'd1, 7'd120);

    // continuous requests from both sides
    gnt_log.delete();
    @(negedge Clock_tb);
    op_a = OP_DEP; acct_a = 2'd3; amt_a = 7'd1;
    op_b = OP_WDR; acct_b = 2'd3; amt_b = 7'd2;
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) model_txn(REQ_A, OP_DEP, 2'd3, 7'd1);
      else            model_txn(REQ_B, OP_WDR, 2'd3, 7'd2);
    end
    req_a = 1'b1;
    req_b = 1'b1;
    na = 0;
    nb = 0;
    for (int c = 0; c < 200 && (na < 3 || nb < 3); c++) begin
      @(negedge Clock_tb);
      if (done_a) begin na++; if (na == 3) req_a = 1'b0; end
      if (done_b) begin nb++; if (nb == 3) req_b = 1'b0; end
    end
    req_a = 1'b0;
    req_b = 1'b0;
    chk("fair_cnt_a", na, 32'd3);
    chk("fair_cnt_b", nb, 32'd3);
    chk("fair_len", gnt_log.size(), 32'd6);
    for (int k = 0; k < 6 && k < gnt_log.size(); k++) begin
      chk("fair_order", {31'b0, gnt_log[k]}, 32'(k % 2));
    end

    // insufficient funds and reserved opcode
    txn(REQ_A, OP_WDR, 2'd0, 7'd127);
    txn(REQ_A, OP_WDR, 2'd0, 7'd127);
    txn(REQ_B, OP_WDR, 2'd0, 7'd127);
    txn(REQ_A, OP_WDR, 2'd0, 7'd19);
    txn(REQ_B, OP_WDR, 2'd0, 7'd127);
    txn(REQ_A, OP_BAL, 2'd0, 7'd0);
    txn(REQ_B, OP_RSV, 2'd0, 7'd5);
    txn(REQ_A, OP_BAL, 2'd0, 7'd0);

    // deposit ceiling and zero amounts
    for (int k = 0; k < 4; k++) txn(k[0], OP_DEP, 2'd2, 7'd127);
    txn(REQ_A, OP_DEP, 2'd2, 7'd10);
    txn(REQ_B, OP_DEP, 2'd2, 7'd6);
    txn(REQ_A, OP_DEP, 2'd2, 7'd5);
    txn(REQ_B, OP_DEP, 2'd2, 7'd0);
    txn(REQ_A, OP_WDR, 2'd2, 7'd0);
    txn(REQ_B, OP_BAL, 2'd2, 7'd0);

    // reset while a withdraw is executing
    @(negedge Clock_tb);
    op_a = OP_WDR; acct_a = 2'd1; amt_a = 7'd50; req_a = 1'b1;
    @(posedge Clock_tb);
    #1;
    chk("pre_rst_exec", {30'b0, dbg_state}, 32'(EXEC));
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_gnt", {31'b0, gnt_a}, 32'd0);
    req_a = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clock_tb);
      chk("mid_rst_nodone", {30'b0, done_a, done_b}, 32'd0);
    end
    for (int i = 0; i < 4; i++) model_bal[i] = 500;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) txn(REQ_A, OP_BAL, 2'(i), 7'd0);
    txn(REQ_A, OP_WDR, 2'd1, 7'd50);

    repeat (2) @(negedge Clock_tb);
    chk("sb_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/atm_account_arbiter.md
Name: atm_account_arbiter

Overview:
Shared account-store controller that lets two ATM front-ends (A and B) run transactions against one bank of account balance registers. Serialises requests with a 2-way round-robin arbiter. Executes balance-query, deposit and withdraw with funds and overflow checks, and returns a per-requester result through a request/done handshake. Sits between the ATM session FSMs and the balance storage, replacing per-ATM private balance registers.

Parameters:
NUM_ACCOUNTS, 4, number of account balance registers
ACCT_W, 2, account index width (clog2 NUM_ACCOUNTS)
BAL_W, 32, balance width
AMT_W, 7, transaction amount width
INIT_BALANCE, 500, reset value of every account
MAX_BALANCE, 2**BAL_W-1, deposit ceiling

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
req_a  input  1  requester A transaction request, held until done_a
op_a  input  2  A opcode: 00 balance, 01 deposit, 10 withdraw, 11 reserved
acct_a  input  ACCT_W  A account index
amt_a  input  AMT_W  A amount, unsigned
req_b / op_b / acct_b / amt_b  input  as above  requester B
gnt_a, gnt_b  output  1  transaction of that requester in progress
done_a, done_b  output  1  one-cycle completion pulse
ok_a, ok_b  output  1  result status, valid with done, held after
bal_a, bal_b  output  BAL_W  post-transaction balance, valid with done, held after
busy  output  1  FSM not in IDLE

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; all balances=INIT_BALANCE; gnt/done/ok=0; bal_a/bal_b=0; last_grant=B, so A wins the first tie. An in-flight transaction is abandoned and no done is issued.
- FSM states: IDLE, EXEC, RESP.
- IDLE: samples req_a/req_b each edge.
  - One request: grant it.
  - Both requests: grant the requester not equal to last_grant.
  - On grant: latch op/acct/amt, set gnt_x=1, update last_grant, go to EXEC.
- EXEC, one cycle: compute and write back.
  - 00 balance: ok=1, no write.
  - 01 deposit: if bal+amt > MAX_BALANCE (computed at BAL_W+1 bits), ok=0 and no write. Else bal+=amt, ok=1.
  - 10 withdraw: if amt > bal, ok=0 and no write. Else bal-=amt, ok=1.
  - 11 reserved: ok=0, no write.
  - acct >= NUM_ACCOUNTS: ok=0, no write.
  - amt=0: deposit/withdraw give ok=1 and leave the balance unchanged.
  - bal_x = resulting (or unchanged) balance.
  - Then go to RESP.
- RESP, one cycle: done_x=1, gnt_x stays 1. Requests are not sampled. Next edge: done_x=0, gnt_x=0, go to IDLE.
- Latency: req sampled at edge t0; done_x high in the cycle after edge t1; next grant possible at edge t3.
- Requester rule: req_x must drop on the edge after done_x is seen. A req still high in IDLE starts a new transaction.
- Fairness: under continuous requests from both sides, grants strictly alternate A, B, A, B.
- Only the granted side's inputs are latched. The other side's inputs may change freely.
- ok_x and bal_x hold their values until that requester's next done.
- Same-account access from A and B is serialised; B's transaction sees A's write-back.

Decomposition:
- Package atm_pkg:
  - opcode constants OP_BAL, OP_DEP, OP_WDR, OP_RSV
  - FSM state enum (IDLE, EXEC, RESP)
  - requester id constants (REQ_A, REQ_B)
- Sub-module rr_arbiter_2:
  - combinational 2-way round-robin pick from req_a, req_b and last_grant
  - last_grant register held in the parent

Test Plan:
- Reset then A balance query on acct 0 → done_a 2 edges after sampling, ok_a=1, bal_a=500; B outputs idle.
- A deposits 100 to acct 1, then B withdraws 120 from acct 1 → bal_a=600, then bal_b=480, both ok=1.
- A and B requesting simultaneously and continuously for 6 transactions → gnt order A,B,A,B,A,B; never both gnt high.
- B withdraws 127 from an account holding 100 → ok_b=0, bal_b=100, stored balance unchanged. Opcode 11 → ok=0, no write.
- Preload acct 2 to MAX_BALANCE-5, deposit 6 → ok=0, balance unchanged. Deposit 5 → ok=1, balance=MAX_BALANCE.
- Assert reset during EXEC of a withdraw → no done pulse, all balances 500, busy=0. After release, a new A request completes normally.
